model_small_decoder: RTL and testbench
======================================

# model_small_decoder

Time-multiplexed decoder half of the small autoencoder: it takes the 16-element latent vector produced by the encoder, reconstructs a 16-element output through Dense7 → ReLU Act8 → Dense9, and returns the raw Dense9 accumulators. It computes one neuron per cycle with a single-row datapath instead of 16 parallel rows, and uses valid/ready handshakes on both sides. Weights are loaded through the same serial `copy`/`k` shift chain used by the encoder, so one weight loader serves both halves.

## Interface
- `XD`, 16, latent elements (= Dense7 inputs)
- `XB`, 17, latent element width, unsigned (encoder ReLU output)
- `HD`, 16, hidden neurons (Dense7 outputs = Dense9 inputs)
- `YD`, 16, output elements
- `KB`, 8, signed weight/bias width
- `H_XB`, `XB+KB+$clog2(XD+1)` = 30, Dense7 accumulator width
- `ACT8_XBF`, 20; `ACT8_YBQ`, 16; `ACT8_YBI`, 3; `ACT8_NEGATIVE_SLOPE`, 0; `HB` = `ACT8_YBQ+1` = 17, hidden width
- `YB`, `HB+KB+$clog2(HD+1)` = 30, signed output width
- `WEIGHTS_B`, `(XD*HD+HD+HD*YD+YD)*KB` = 4352
- `clk` in 1: clock. One clock domain only.
- `rstn` in 1: reset. Synchronous and active-low.
- `copy` in 1: weight-chain shift enable.
- `k` in 1: weight-chain serial bit.
- `s_valid` in 1, `s_ready` out 1, `x` in `[XD][XB]`: latent input handshake.
- `m_valid` out 1, `m_ready` in 1, `y` out `[YD][YB]`: output handshake.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Weight chain:
  - When `copy && state==IDLE`, the chain shifts: `w <= {k, w[WEIGHTS_B-1:1]}`. In any other state the chain holds and `copy` is ignored.
  - Packing is `{dense9_b, dense9_k, dense7_b, dense7_k}`, with LSB first out of the chain.
  - Kernel element for output `j`, input `i` is at index `j*XD+i`. Bias for output `j` is at index `j`.
- FSM states: IDLE, L1, L2, DONE. Index counter `j` is 4 bits.
  - IDLE:
    - `s_ready = !copy`.
    - On `s_valid && s_ready`: latch `x` into `xr`, set `j=0`, go to L1.
  - L1: `h[j] <= Act8(b7[j] + Σ_i k7[j][i]*xr[i])`.
    - At `j==HD-1`: set `j=0`, go to L2. Otherwise `j++`.
  - L2: `y[j] <= b9[j] + Σ_i k9[j][i]*h[i]`.
    - At `j==YD-1`: go to DONE.
  - DONE:
    - `m_valid=1`; `y` is stable.
    - On `m_ready`: go to IDLE. No new input is accepted in the same cycle.
- Arithmetic and widths:
  - Multiplies are signed weight × unsigned activation.
  - Accumulation runs at full width (`H_XB`, `YB`). The datapath never saturates, and no rounding happens outside Act8.
- `s_ready` is low in L1, L2 and DONE. `s_valid` is ignored there and `x` is not sampled.

## Timing
- Accept at edge T. L1 occupies T+1..T+16 and L2 occupies T+17..T+32. `m_valid` rises at T+33.
- Minimum period between accepts is 34 cycles.
- `m_valid` and `y` hold until `m_ready` is sampled high. `s_ready` rises in the following cycle, if `copy` is low.
- Reset values (one edge with `rstn=0`):
  - state IDLE, `j=0`
  - `m_valid=0`, `busy=0`
  - `y`, `h`, `xr` all 0
  - whole weight chain 0
  - `s_ready=1` while `copy=0`
- Reset mid-operation discards the computation and clears the weights. Software must reload the chain afterwards.
- Simultaneous events:
  - `copy` and `s_valid` together in IDLE: the shift wins and the input is not accepted.
  - `m_ready` asserted before DONE has no effect.

## Structure
- Package `model_small_decoder_pkg` holds:
  - all width and size localparams listed above
  - `WEIGHTS_B` and the chain field offsets
  - an FSM state enum `dec_state_t`
- Reused sub-modules:
  - `register`, for the weight chain
  - `qdense` with `YD=1`, once per layer, fed by muxed row `j`
  - `qact` with `N=1`, for Act8
- One new sub-module is natural: `decoder_row_sel`, the kernel/bias row mux indexed by `j` for both layers.

## Test plan
- Reset: after reset, `m_valid=0`, `busy=0`, `s_ready=1`, `y` all 0; shifting 4352 zeros leaves all weights 0.
- Zero-path: `k7=0`, `b7=-5` (Act8 → 0), `k9=1`, `b9=3`; send any `x` → exactly 33 cycles after accept, `m_valid=1` with every `y[j]=3`.
- Row order: `k7=0`, `b7=0`, `k9=0`, `b9[j]=j-8`; any `x` → `y[j]=j-8`, sign-extended to 30 bits.
- Backpressure: hold `m_ready=0` for 10 cycles after `m_valid` → `y` stable, `s_ready=0`, and a `s_valid` pulse is not accepted; `m_ready=1` → IDLE the next cycle.
- Copy gating: toggle `copy` with random `k` during L1/L2 → result equals the no-copy golden result and the chain is unchanged. In IDLE, `copy=1` forces `s_ready=0`.
- Mid-op reset: `rstn=0` at L2 cycle 5 → next cycle IDLE, `m_valid=0`, all weights 0; after reload, the next frame matches the golden model.

Source files
------------

// File: rtl/model_small_decoder_pkg.sv
// Shared sizes, weight-chain layout and FSM encoding for the decoder half
// of the small autoencoder.
package model_small_decoder_pkg;

  localparam int XD   = 16;
  localparam int XB   = 17;
  localparam int HD   = 16;
  localparam int YD   = 16;
  localparam int KB   = 8;
  localparam int H_XB = XB + KB + $clog2(XD + 1);

  localparam int ACT8_XBF            = 20;
  localparam int ACT8_YBQ            = 16;
  localparam int ACT8_YBI            = 3;
  localparam int ACT8_NEGATIVE_SLOPE = 0;
  localparam int HB                  = ACT8_YBQ + 1;

  localparam int YB        = HB + KB + $clog2(HD + 1);
  localparam int WEIGHTS_B = (XD*HD + HD + HD*YD + YD) * KB;
  localparam int WB_AW     = $clog2(WEIGHTS_B);

  // Chain fields, LSB first: {dense9_b, dense9_k, dense7_b, dense7_k}
  localparam int K7_OFF = 0;
  localparam int B7_OFF = K7_OFF + XD*HD*KB;
  localparam int K9_OFF = B7_OFF + HD*KB;
  localparam int B9_OFF = K9_OFF + HD*YD*KB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_L1   = 2'd1,
    ST_L2   = 2'd2,
    ST_DONE = 2'd3
  } dec_state_t;

endpackage

// File: rtl/decoder_row_sel.sv
// Picks the kernel row and bias of neuron j for both decoder layers out of
// the flat weight chain.
module decoder_row_sel
  import model_small_decoder_pkg::*;
(
  input  logic [WEIGHTS_B-1:0]   w,
  input  logic [3:0]             j,
  output logic [XD-1:0][KB-1:0]  k7_row,
  output logic [KB-1:0]          b7,
  output logic [HD-1:0][KB-1:0]  k9_row,
  output logic [KB-1:0]          b9
);

  logic [WB_AW-1:0] k7_base;
  logic [WB_AW-1:0] b7_base;
  logic [WB_AW-1:0] k9_base;
  logic [WB_AW-1:0] b9_base;

  assign k7_base = WB_AW'(K7_OFF) + WB_AW'(j) * WB_AW'(XD*KB);
  assign b7_base = WB_AW'(B7_OFF) + WB_AW'(j) * WB_AW'(KB);
  assign k9_base = WB_AW'(K9_OFF) + WB_AW'(j) * WB_AW'(HD*KB);
  assign b9_base = WB_AW'(B9_OFF) + WB_AW'(j) * WB_AW'(KB);

  assign k7_row = w[k7_base +: XD*KB];
  assign b7     = w[b7_base +: KB];
  assign k9_row = w[k9_base +: HD*KB];
  assign b9     = w[b9_base +: KB];

endmodule

// File: rtl/qact.sv
// Quantising activation: optional negative slope, rescale from XBF fractional
// bits to YBQ-YBI fractional bits (truncating), then clamp to unsigned YB bits.
module qact #(
  parameter int N              = 1,
  parameter int XB             = 30,
  parameter int XBF            = 20,
  parameter int YBQ            = 16,
  parameter int YBI            = 3,
  parameter int NEGATIVE_SLOPE = 0,
  parameter int YB             = YBQ + 1
) (
  input  logic [N-1:0][XB-1:0] x,
  output logic [N-1:0][YB-1:0] y
);

  localparam int            SH    = XBF - (YBQ - YBI);
  localparam logic [XB-1:0] SLOPE = XB'(NEGATIVE_SLOPE);

  for (genvar n = 0; n < N; n++) begin : g_ch
    logic [XB-1:0] scaled;
    logic [XB-1:0] shifted;
    logic [YB-1:0] r;

    // Negative inputs end at zero because the output is unsigned.
    always_comb begin
      scaled  = x[n][XB-1] ? x[n] * SLOPE : x[n];
      shifted = $signed(scaled) >>> SH;
      if (shifted[XB-1]) begin
        r = {YB{1'b0}};
      end else if (|shifted[XB-2:YB]) begin
        r = {YB{1'b1}};
      end else begin
        r = shifted[YB-1:0];
      end
    end

    assign y[n] = r;
  end

endmodule

// File: rtl/qdense.sv
// Combinational dense layer: signed KB-bit weights times unsigned activations,
// accumulated at full width YB on top of a sign-extended bias.
module qdense #(
  parameter int XD = 16,
  parameter int XB = 17,
  parameter int YD = 1,
  parameter int KB = 8,
  parameter int YB = 30
) (
  input  logic [XD-1:0][XB-1:0]         x,
  input  logic [YD-1:0][XD-1:0][KB-1:0] k,
  input  logic [YD-1:0][KB-1:0]         b,
  output logic [YD-1:0][YB-1:0]         y
);

  localparam int PB = XB + KB + 1;

  // Low PB bits of the two's-complement product are exact for this range.
  function automatic logic [YB-1:0] mac_term(input logic [KB-1:0] kk,
                                             input logic [XB-1:0] xx);
    logic [PB-1:0] ke;
    logic [PB-1:0] xe;
    logic [PB-1:0] p;
    ke = {{(XB+1){kk[KB-1]}}, kk};
    xe = {{(KB+1){1'b0}}, xx};
    p  = ke * xe;
    return {{(YB-PB){p[PB-1]}}, p};
  endfunction

  for (genvar o = 0; o < YD; o++) begin : g_row
    logic [YB-1:0] acc;

    // Bias plus sum of products for one output neuron.
    always_comb begin
      acc = {{(YB-KB){b[o][KB-1]}}, b[o]};
      for (int i = 0; i < XD; i++) begin
        acc = acc + mac_term(k[o][i], x[i]);
      end
    end

    assign y[o] = acc;
  end

endmodule

// File: rtl/register.sv
// Plain enabled register with synchronous active-low clear.
module register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage: clear on reset, load when enabled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/model_small_decoder.sv
// Decoder half of the small autoencoder: Dense7 -> Act8 -> Dense9, one neuron
// per cycle over a single shared row datapath, weights from a serial chain.
module model_small_decoder
  import model_small_decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  copy,
  input  logic                  k,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [XD-1:0][XB-1:0] x,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [YD-1:0][YB-1:0] y,
  output logic                  busy
);

  dec_state_t            state;
  logic [3:0]            j;
  logic [XD-1:0][XB-1:0] xr;
  logic [HD-1:0][HB-1:0] h;
  logic [WEIGHTS_B-1:0]  w;
  logic                  shift_en;

  logic [XD-1:0][KB-1:0] k7_row;
  logic [KB-1:0]         b7_val;
  logic [HD-1:0][KB-1:0] k9_row;
  logic [KB-1:0]         b9_val;
  logic [H_XB-1:0]       acc7;
  logic [HB-1:0]         act8;
  logic [YB-1:0]         acc9;

  // The chain only moves while idle so a running frame sees frozen weights.
  assign shift_en = copy && (state == ST_IDLE);
  assign s_ready  = (state == ST_IDLE) && !copy;
  assign m_valid  = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);

  register #(.W(WEIGHTS_B)) u_chain (
    .clk  (clk),
    .rstn (rstn),
    .en   (shift_en),
    .d    ({k, w[WEIGHTS_B-1:1]}),
    .q    (w)
  );

  decoder_row_sel u_rows (
    .w      (w),
    .j      (j),
    .k7_row (k7_row),
    .b7     (b7_val),
    .k9_row (k9_row),
    .b9     (b9_val)
  );

  qdense #(.XD(XD), .XB(XB), .YD(1), .KB(KB), .YB(H_XB)) u_dense7 (
    .x (xr),
    .k (k7_row),
    .b (b7_val),
    .y (acc7)
  );

  qact #(
    .N(1), .XB(H_XB), .XBF(ACT8_XBF), .YBQ(ACT8_YBQ), .YBI(ACT8_YBI),
    .NEGATIVE_SLOPE(ACT8_NEGATIVE_SLOPE), .YB(HB)
  ) u_act8 (
    .x (acc7),
    .y (act8)
  );

  qdense #(.XD(HD), .XB(HB), .YD(1), .KB(KB), .YB(YB)) u_dense9 (
    .x (h),
    .k (k9_row),
    .b (b9_val),
    .y (acc9)
  );

  // Frame sequencer: accept, hidden layer, output layer, hold result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      j     <= 4'd0;
      xr    <= '0;
      h     <= '0;
      y     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid && !copy) begin
            xr    <= x;
            j     <= 4'd0;
            state <= ST_L1;
          end
        end
        ST_L1: begin
          h[j] <= act8;
          if (j == 4'(HD-1)) begin
            j     <= 4'd0;
            state <= ST_L2;
          end else begin
            j <= j + 4'd1;
          end
        end
        ST_L2: begin
          y[j] <= acc9;
          j    <= j + 4'd1;
          if (j == 4'(YD-1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (m_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_small_decoder.sv
// Directed bench for model_small_decoder: weight loading, frame latency,
// row ordering, backpressure, copy gating and mid-operation reset.
module tb_model_small_decoder;
  import model_small_decoder_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn, copy, k, s_valid, s_ready, m_valid, m_ready, busy;
  logic [XD-1:0][XB-1:0] x;
  logic [YD-1:0][YB-1:0] y;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int k7[16][16];
  int b7[16];
  int k9[16][16];
  int b9[16];
  longint yexp[16];
  logic [WEIGHTS_B-1:0]  wvec;
  logic [XD-1:0][XB-1:0] xa, xb2;
  logic [YD-1:0][YB-1:0] y_snap;

  always #5 clk = ~clk;

  model_small_decoder dut (
    .clk(clk), .rstn(rstn), .copy(copy), .k(k),
    .s_valid(s_valid), .s_ready(s_ready), .x(x),
    .m_valid(m_valid), .m_ready(m_ready), .y(y), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WEIGHTS_B-1:0] pack_w();
    logic [WEIGHTS_B-1:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) begin
        v[K7_OFF + (j*XD + i)*KB +: KB] = KB'(k7[j][i]);
        v[K9_OFF + (j*HD + i)*KB +: KB] = KB'(k9[j][i]);
      end
      v[B7_OFF + j*KB +: KB] = KB'(b7[j]);
      v[B9_OFF + j*KB +: KB] = KB'(b9[j]);
    end
    return v;
  endfunction

  // Shift the packed image in, bit 0 first.
  task automatic load();
    wvec = pack_w();
    for (int b = 0; b < WEIGHTS_B; b++) begin
      copy = 1'b1;
      k    = wvec[b];
      tick();
    end
    copy = 1'b0;
    k    = 1'b0;
  endtask

  task automatic set_weights(input int mode);
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) begin
        k7[j][i] = (mode == 3) ? ((j == 0) ? 127 : ((j*7 + i*3) % 15) - 7) : 0;
        k9[j][i] = (mode == 1) ? 1 : (mode == 3) ? ((i*5 + j*11) % 13) - 6 : 0;
      end
      b7[j] = (mode == 1) ? -5 : (mode == 3) ? j*9 - 60 : 0;
      b9[j] = (mode == 1) ? 3 : (mode == 2) ? j - 8 : (mode == 3) ? 100 - j*13 : 0;
    end
    if (mode == 3) k9[15][0] = -128;
  endtask

  task automatic golden(input logic [XD-1:0][XB-1:0] xin);
    longint hh[16];
    longint a;
    for (int j = 0; j < 16; j++) begin
      a = longint'(b7[j]);
      for (int i = 0; i < 16; i++) a += longint'(k7[j][i]) * longint'(xin[i]);
      if (a < 0) hh[j] = 0;
      else begin
        hh[j] = a / 128;
        if (hh[j] > 131071) hh[j] = 131071;
      end
    end
    for (int j = 0; j < 16; j++) begin
      a = longint'(b9[j]);
      for (int i = 0; i < 16; i++) a += longint'(k9[j][i]) * hh[i];
      yexp[j] = a;
    end
  endtask

  // Accept one frame and check latency; noisy mode wiggles ignored inputs.
  task automatic run_frame(input logic [XD-1:0][XB-1:0] xin, input bit noisy);
    x       = xin;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    x       = ~xin;
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_s_ready", 64'(s_ready), 64'd0);
    for (int c = 1; c <= 31; c++) begin
      if (noisy) begin
        copy    = 1'($urandom_range(0, 1));
        k       = 1'($urandom_range(0, 1));
        m_ready = 1'(c >= 3 && c <= 6);
        s_valid = 1'(c == 10);
      end
      tick();
    end
    copy = 1'b0; k = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
    chk("m_valid_before_33", 64'(m_valid), 64'd0);
    tick();
    tick();
    chk("m_valid_at_33", 64'(m_valid), 64'd1);
    chk("done_s_ready", 64'(s_ready), 64'd0);
  endtask

  task automatic finish_frame();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("release_busy", 64'(busy), 64'd0);
    chk("release_m_valid", 64'(m_valid), 64'd0);
    chk("release_s_ready", 64'(s_ready), 64'd1);
  endtask

  task automatic check_y(input string tag);
    logic [YB-1:0] e;
    for (int j = 0; j < 16; j++) begin
      e = YB'(yexp[j]);
      chk($sformatf("%s[%0d]", tag, j), 64'(y[j]), 64'(e));
    end
  endtask

  initial begin
    rstn = 1'b0; copy = 1'b0; k = 1'b0; s_valid = 1'b0; m_ready = 1'b0; x = '0;
    for (int i = 0; i < 16; i++) begin
      xa[i]  = XB'(8000*i + 1234);
      xb2[i] = XB'(i*i*431 + 77);
    end
    tick();
    tick();
    rstn = 1'b1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_y_ones", 64'($countones(y)), 64'd0);
    chk("rst_chain_ones", 64'($countones(dut.w)), 64'd0);

    copy = 1'b1;
    #1;
    chk("copy_blocks_s_ready", 64'(s_ready), 64'd0);
    copy = 1'b0;
    #1;

    set_weights(0);
    load();
    chk("zero_load_chain", 64'($countones(dut.w ^ wvec)), 64'd0);

    // copy and s_valid together: the shift wins
    copy = 1'b1; k = 1'b0; s_valid = 1'b1; x = xa;
    tick();
    copy = 1'b0; s_valid = 1'b0;
    chk("copy_beats_s_valid", 64'(busy), 64'd0);

    set_weights(1);
    load();
    chk("zp_load_chain", 64'($countones(dut.w ^ wvec)), 64'd0);
    for (int j = 0; j < 16; j++) yexp[j] = 3;
    run_frame(xa, 1'b0);
    check_y("y_zero_path");
    finish_frame();

    set_weights(2);
    load();
    for (int j = 0; j < 16; j++) yexp[j] = j - 8;
    run_frame(xb2, 1'b0);
    check_y("y_row_order");
    y_snap = y;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'(c == 4);
      x       = xa;
      tick();
    end
    s_valid = 1'b0;
    chk("bp_y_stable", 64'($countones(y ^ y_snap)), 64'd0);
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    finish_frame();

    set_weights(3);
    load();
    golden(xa);
    run_frame(xa, 1'b1);
    check_y("y_golden_noisy");
    chk("noisy_chain_unchanged", 64'($countones(dut.w ^ wvec)), 64'd0);
    finish_frame();

    // Reset in the fifth L2 cycle
    x = xb2; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_chain_ones", 64'($countones(dut.w)), 64'd0);
    chk("midrst_y_ones", 64'($countones(y)), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);

    load();
    golden(xb2);
    run_frame(xb2, 1'b0);
    check_y("y_after_reload");
    finish_frame();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
